// File: rtl/logic_thief_pkg.sv
// rtl/logic_thief_pkg.sv - shared commands, FSM states and slice-count helper for the logic thief readout
package logic_thief_pkg;

  localparam logic [31:0] CMD_START = 32'hC0FFEE01;
  localparam logic [31:0] CMD_ABORT = 32'hDEADDEAD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Number of software words per capture entry; slice_o is 3 bits so at most 8.
  function automatic int slice_count(input int data_w, input int word_w);
    return data_w / word_w;
  endfunction

endpackage

// File: rtl/logic_thief_readout_if.sv
// rtl/logic_thief_readout_if.sv - command, thief read port and software word handshake bundle
interface logic_thief_readout_if #(
  parameter int DATA_W = 192,
  parameter int DEEP   = 8,
  parameter int WORD_W = 32
);

  logic [31:0]       cmd_i;
  logic [DATA_W-1:0] thief_data_i;
  logic [31:0]       thief_addr_o;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              rd_next_i;
  logic [DEEP-1:0]   entry_o;
  logic [2:0]        slice_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  // Drain engine side.
  modport master (
    input  cmd_i, thief_data_i, rd_next_i,
    output thief_addr_o, word_o, word_valid_o, entry_o, slice_o, busy_o, done_o, err_o
  );

  // Software / thief side.
  modport slave (
    output cmd_i, thief_data_i, rd_next_i,
    input  thief_addr_o, word_o, word_valid_o, entry_o, slice_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/logic_thief_slice_mux.sv
// rtl/logic_thief_slice_mux.sv - holds one capture entry and selects the current software word
module logic_thief_slice_mux #(
  parameter int DATA_W = 192,
  parameter int WORD_W = 32,
  parameter int NSLICE = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_slice,
  output logic [WORD_W-1:0] o_word
);

  logic [DATA_W-1:0] r_hold;

  // Capture the wide thief word once per entry so the thief address may move on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold <= '0;
    end else if (i_load) begin
      r_hold <= i_data;
    end
  end

  // Slice 0 is the least significant word; out-of-range indices read as zero.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (i_slice == 3'(i)) begin
        o_word = r_hold[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/logic_thief_readout.sv
// rtl/logic_thief_readout.sv - drains every logic thief capture entry to software word by word
module logic_thief_readout
  import logic_thief_pkg::*;
#(
  parameter int LOGTHIEF_DATA_WIDTH = 192,
  parameter int LOGTHIEF_LOG2_DEEP  = 8,
  parameter int WORD_WIDTH          = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  logic_thief_readout_if.master bus
);

  localparam int NSLICE = slice_count(LOGTHIEF_DATA_WIDTH, WORD_WIDTH);
  localparam logic [2:0] LAST_SLICE = 3'(NSLICE - 1);
  localparam logic [LOGTHIEF_LOG2_DEEP-1:0] LAST_ENTRY = '1;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [LOGTHIEF_LOG2_DEEP-1:0] r_entry;
  logic [LOGTHIEF_LOG2_DEEP-1:0] w_entry_inc;
  logic [2:0]                    r_slice;
  logic [31:0]                   r_thief_addr;
  logic                          r_done;
  logic                          r_err;
  logic                          r_start_prev;
  logic                          w_is_start;
  logic                          w_start_edge;
  logic                          w_abort;
  logic                          w_complete;
  logic                          w_last_slice;
  logic                          w_last_entry;
  logic                          w_idle_like;
  logic                          w_present;
  logic                          w_valid;
  logic                          w_busy;
  logic                          w_load;
  logic [WORD_WIDTH-1:0]         w_word;

  assign w_is_start   = (bus.cmd_i == CMD_START);
  assign w_abort      = (bus.cmd_i == CMD_ABORT);
  // Software holds the command level; only a fresh START may launch a drain.
  assign w_start_edge = w_is_start && !r_start_prev;
  assign w_complete   = bus.thief_data_i[LOGTHIEF_DATA_WIDTH-1];
  assign w_last_slice = (r_slice == LAST_SLICE);
  assign w_last_entry = (r_entry == LAST_ENTRY);
  assign w_entry_inc  = r_entry + 1'b1;
  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_present    = (r_state == ST_PRESENT);
  assign w_load       = (r_state == ST_LATCH);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and status outputs; ABORT overrides every transition.
  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_edge && w_complete) w_state_next = ST_ADDR;
      end
      ST_ADDR: begin
        w_busy       = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy       = 1'b1;
        w_state_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_busy       = 1'b1;
        w_state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        if (bus.rd_next_i && w_last_slice) begin
          w_state_next = w_last_entry ? ST_DONE : ST_ADDR;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_abort) w_state_next = ST_IDLE;
  end

  // Entry/slice counters, thief address and sticky done/error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_entry      <= '0;
      r_slice      <= '0;
      r_thief_addr <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_start_prev <= w_is_start;
      if (w_abort) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else if (w_idle_like && w_start_edge) begin
        if (w_complete) begin
          r_entry      <= '0;
          r_slice      <= '0;
          r_thief_addr <= '0;
          r_done       <= 1'b0;
          r_err        <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (w_load) begin
        r_slice <= '0;
      end else if (w_present && bus.rd_next_i) begin
        if (!w_last_slice) begin
          r_slice <= r_slice + 3'd1;
        end else if (w_last_entry) begin
          r_done <= 1'b1;
        end else begin
          r_entry      <= w_entry_inc;
          r_thief_addr <= {{(32-LOGTHIEF_LOG2_DEEP){1'b0}}, w_entry_inc};
        end
      end
    end
  end

  logic_thief_slice_mux #(
    .DATA_W (LOGTHIEF_DATA_WIDTH),
    .WORD_W (WORD_WIDTH),
    .NSLICE (NSLICE)
  ) u_slice_mux (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_load  (w_load),
    .i_data  (bus.thief_data_i),
    .i_slice (r_slice),
    .o_word  (w_word)
  );

  assign bus.thief_addr_o = r_thief_addr;
  assign bus.word_o       = w_word;
  assign bus.word_valid_o = w_valid;
  assign bus.entry_o      = r_entry;
  assign bus.slice_o      = r_slice;
  assign bus.busy_o       = w_busy;
  assign bus.done_o       = r_done;
  assign bus.err_o        = r_err;

endmodule
